// File: rtl/bcd_seq_addsub_pkg.sv
// bcd_pkg: shared BCD constants, FSM state type and digit validity check.
package bcd_pkg;
  localparam int DIGIT_W = 4;
  localparam int BCD_MAX = 9;
  localparam int BCD_CORR = 6;
  typedef enum logic [1:0] {IDLE, ADD, NEG, DONE} state_e;
  function automatic logic digit_valid(input logic [DIGIT_W-1:0] d);
    return d <= 4'(BCD_MAX);
  endfunction
endpackage

// File: rtl/bcd_seq_addsub_if.sv
// bcd_seq_addsub_if: start/busy/done request and result bundle.
interface bcd_seq_addsub_if #(parameter int DIGITS = 4);
  logic start;
  logic mode;
  logic [4*DIGITS-1:0] a;
  logic [4*DIGITS-1:0] b;
  logic cin;
  logic busy;
  logic done;
  logic [4*DIGITS-1:0] sum;
  logic cout;
  logic neg;
  logic err;
  modport master (output start, mode, a, b, cin, input busy, done, sum, cout, neg, err);
  modport slave (input start, mode, a, b, cin, output busy, done, sum, cout, neg, err);
endinterface

// File: rtl/bcd_seq_addsub_digit_cell.sv
// bcd_digit_cell: single-digit BCD add with decimal (+6) correction.
module bcd_digit_cell
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [4:0] t;
  always_comb begin
    t = 5'(x) + 5'(y) + 5'(ci);
    co = t > 5'(BCD_MAX);
    s = co ? 4'(t + 5'(BCD_CORR)) : t[3:0];
  end
endmodule

// File: rtl/bcd_seq_addsub.sv
// bcd_seq_addsub: digit-serial N-digit BCD add/subtract, LSD first, sign/magnitude result.
module bcd_seq_addsub
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input logic clk,
  input logic rst,
  bcd_seq_addsub_if.slave bus
);
  localparam int W = DIGIT_W * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  state_e state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d, acc_sh;
  logic [CW-1:0] cnt_q, cnt_d;
  logic mode_q, mode_d, carry_q, carry_d, cout_q, cout_d, neg_q, neg_d, err_q, err_d;
  logic [3:0] x, y, s;
  logic co, ok, last, accept;
  bcd_digit_cell u_cell (.x(x), .y(y), .ci(carry_q), .s(s), .co(co));
  always_comb begin
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      ok = ok & digit_valid(bus.a[DIGIT_W*i +: DIGIT_W]) & digit_valid(bus.b[DIGIT_W*i +: DIGIT_W]);
    // NEG pass reuses the cell: ten's complement = (9 - R_i) + carry, carry seeded with 1
    x = (state_q == NEG) ? 4'(BCD_MAX) - acc_q[3:0] : a_q[3:0];
    y = (state_q == NEG) ? 4'd0 : mode_q ? 4'(BCD_MAX) - b_q[3:0] : b_q[3:0];
    acc_sh = W'({s, acc_q} >> DIGIT_W);
    last = cnt_q == CW'(DIGITS - 1);
    accept = bus.start && (state_q == IDLE || state_q == DONE);
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    sum_d = sum_q;
    cnt_d = cnt_q;
    mode_d = mode_q;
    carry_d = carry_q;
    cout_d = cout_q;
    neg_d = neg_q;
    err_d = err_q;
    if (state_q == ADD || state_q == NEG) begin
      acc_d = acc_sh;
      carry_d = co;
      cnt_d = cnt_q + 1'b1;
      a_d = a_q >> DIGIT_W;
      b_d = b_q >> DIGIT_W;
      if (last && state_q == ADD && mode_q && !co) begin
        state_d = NEG;
        carry_d = 1'b1;
        cnt_d = '0;
      end else if (last) begin
        state_d = DONE;
        sum_d = acc_sh;
        cout_d = !mode_q && co;
        neg_d = state_q == NEG;
        err_d = 1'b0;
      end
    end else if (accept && !ok) begin
      state_d = DONE;
      sum_d = '0;
      cout_d = 1'b0;
      neg_d = 1'b0;
      err_d = 1'b1;
    end else if (accept) begin
      state_d = ADD;
      a_d = bus.a;
      b_d = bus.b;
      acc_d = '0;
      mode_d = bus.mode;
      carry_d = bus.mode ? ~bus.cin : bus.cin;
      cnt_d = '0;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      sum_q <= '0;
      cnt_q <= '0;
      mode_q <= 1'b0;
      carry_q <= 1'b0;
      cout_q <= 1'b0;
      neg_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      mode_q <= mode_d;
      carry_q <= carry_d;
      cout_q <= cout_d;
      neg_q <= neg_d;
      err_q <= err_d;
    end
  end
  assign bus.busy = state_q == ADD || state_q == NEG;
  assign bus.done = state_q == DONE;
  assign bus.sum = sum_q;
  assign bus.cout = cout_q;
  assign bus.neg = neg_q;
  assign bus.err = err_q;
endmodule

// File: tb/tb_bcd_seq_addsub.sv
// tb_bcd_seq_addsub: directed vectors with a scoreboard queue and a done-triggered monitor.
module tb_bcd_seq_addsub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bcnt = 0;
  typedef struct {
    logic [15:0] sum;
    logic cout, neg, err;
    int dcyc;
    int bexp;
  } exp_t;
  exp_t q[$];
  bcd_seq_addsub_if #(.DIGITS(4)) bus();
  bcd_seq_addsub #(.DIGITS(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.busy) bcnt <= bcnt + 1;
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      exp_t e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done sum=%h cout=%b neg=%b err=%b", bus.sum, bus.cout, bus.neg, bus.err);
      end else begin
        e = q.pop_front();
        if (bus.sum !== e.sum || bus.cout !== e.cout || bus.neg !== e.neg || bus.err !== e.err) begin
          errors++;
          $display("FAIL result got sum=%h cout=%b neg=%b err=%b want sum=%h cout=%b neg=%b err=%b",
                   bus.sum, bus.cout, bus.neg, bus.err, e.sum, e.cout, e.neg, e.err);
        end
        checks++;
        if (cyc != e.dcyc) begin
          errors++;
          $display("FAIL latency got cycle %0d want %0d", cyc, e.dcyc);
        end
        checks++;
        if (bcnt != e.bexp) begin
          errors++;
          $display("FAIL busy_cycles got %0d want %0d", bcnt - (e.bexp - 0), 0);
        end
      end
    end
  end
  task automatic issue(input logic now, input logic push, input logic m, input logic [15:0] a,
                       input logic [15:0] b, input logic ci, input logic [15:0] es, input logic ec,
                       input logic en, input logic ee, input int lat);
    exp_t e;
    if (!now) @(negedge clk);
    bus.start = 1'b1;
    bus.mode = m;
    bus.a = a;
    bus.b = b;
    bus.cin = ci;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    e.sum = es;
    e.cout = ec;
    e.neg = en;
    e.err = ee;
    e.dcyc = cyc + lat - 1;
    e.bexp = bcnt + lat - 1;
    if (push) q.push_back(e);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) return;
    end
    checks++;
    errors++;
    $display("FAIL done_timeout no done within 40 cycles");
  endtask
  task automatic run(input logic m, input logic [15:0] a, input logic [15:0] b, input logic ci,
                     input logic [15:0] es, input logic ec, input logic en, input logic ee, input int lat);
    issue(1'b0, 1'b1, m, a, b, ci, es, ec, en, ee, lat);
    wait_done();
  endtask
  initial begin
    bus.start = 1'b0;
    bus.mode = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.sum, bus.cout, bus.neg, bus.err} !== '0) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b sum=%h cout=%b neg=%b err=%b want all 0",
               bus.busy, bus.done, bus.sum, bus.cout, bus.neg, bus.err);
    end
    rst = 1'b0;
    run(1'b0, 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0, 5);
    run(1'b0, 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 5);
    run(1'b0, 16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b0, 5);
    run(1'b1, 16'h5000, 16'h1234, 1'b0, 16'h3766, 1'b0, 1'b0, 1'b0, 5);
    run(1'b1, 16'h1000, 16'h0001, 1'b1, 16'h0998, 1'b0, 1'b0, 1'b0, 5);
    run(1'b1, 16'h1234, 16'h5000, 1'b0, 16'h3766, 1'b0, 1'b1, 1'b0, 9);
    run(1'b1, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 5);
    run(1'b0, 16'h12A4, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1);
    run(1'b0, 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 5);
    issue(1'b0, 1'b1, 1'b0, 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0, 1'b0, 5);
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode = 1'b1;
    bus.a = 16'h9999;
    bus.b = 16'h8888;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    issue(1'b0, 1'b0, 1'b1, 16'h5000, 16'h1234, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 5);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.sum, bus.cout, bus.neg, bus.err} !== '0) begin
      errors++;
      $display("FAIL mid_reset got busy=%b done=%b sum=%h cout=%b neg=%b err=%b want all 0",
               bus.busy, bus.done, bus.sum, bus.cout, bus.neg, bus.err);
    end
    rst = 1'b0;
    repeat (12) @(negedge clk);
    run(1'b0, 16'h0100, 16'h0200, 1'b0, 16'h0300, 1'b0, 1'b0, 1'b0, 5);
    issue(1'b1, 1'b1, 1'b0, 16'h0005, 16'h0005, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 5);
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL start_in_done busy got %b want 1", bus.busy);
    end
    wait_done();
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
